// File: rtl/instr_pkg.sv
// Shared types and field positions for the ID stage: opcodes, control bundle, ID/EX record.
package instr_pkg;

  localparam int unsigned DefDataW    = 32;
  localparam int unsigned DefRaddrW   = 5;
  localparam int unsigned DefImmW     = 17;
  localparam int unsigned DefSprAddrW = 8;
  localparam int unsigned DefPcW      = 22;

  localparam int unsigned OpLsb  = 27;
  localparam int unsigned RdLsb  = 22;
  localparam int unsigned RsLsb  = 17;
  localparam int unsigned RtLsb  = 12;
  localparam int unsigned ActLsb = 8;

  localparam logic [4:0] HLT_OP = 5'h1F;

  // Opcode classes are selected by op[4:3]
  localparam logic [1:0] ClsAluRr  = 2'b00;
  localparam logic [1:0] ClsAluImm = 2'b01;
  localparam logic [1:0] ClsBranch = 2'b10;
  localparam logic [1:0] ClsMisc   = 2'b11;

  typedef enum logic [4:0] {
    OpLd     = 5'h18,
    OpSt     = 5'h19,
    OpSprRd  = 5'h1C,
    OpSprWr  = 5'h1D,
    OpSprAct = 5'h1E,
    OpHlt    = HLT_OP
  } opcode_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       use_imm;
    logic       use_dst;
    logic       branch;
    logic       load;
    logic       store;
    logic       sprite_re;
    logic       sprite_we;
    logic       sprite_act;
    logic       upd_n;
    logic       upd_c;
    logic       upd_v;
    logic       upd_z;
    logic       re_s;
    logic       re_t;
    logic       is_hlt;
  } ctrl_t;

  typedef struct packed {
    logic [2:0]             alu_op;
    logic [DefImmW-1:0]     imm;
    logic [DefDataW-1:0]    reg_s_data;
    logic [DefDataW-1:0]    reg_t_data;
    logic [DefRaddrW-1:0]   dst_reg;
    logic                   use_imm;
    logic                   use_dst;
    logic                   branch;
    logic                   load;
    logic                   store;
    logic                   sprite_re;
    logic                   sprite_we;
    logic [3:0]             sprite_action;
    logic [DefSprAddrW-1:0] sprite_addr;
    logic                   upd_n;
    logic                   upd_c;
    logic                   upd_v;
    logic                   upd_z;
    logic [DefPcW-1:0]      pc;
  } id_ex_t;

endpackage

// File: rtl/id_field_dec.sv
// Purely combinational opcode -> control bit decoder.
module id_field_dec
  import instr_pkg::*;
(
  input  logic [4:0] op_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (op_i[4:3])
      ClsAluRr: begin
        ctrl_o.alu_op  = op_i[2:0];
        ctrl_o.re_s    = 1'b1;
        ctrl_o.re_t    = 1'b1;
        ctrl_o.use_dst = 1'b1;
        ctrl_o.upd_n   = 1'b1;
        ctrl_o.upd_c   = 1'b1;
        ctrl_o.upd_v   = 1'b1;
        ctrl_o.upd_z   = 1'b1;
      end
      ClsAluImm: begin
        ctrl_o.alu_op  = op_i[2:0];
        ctrl_o.use_imm = 1'b1;
        ctrl_o.re_s    = 1'b1;
        ctrl_o.use_dst = 1'b1;
        ctrl_o.upd_n   = 1'b1;
        ctrl_o.upd_c   = 1'b1;
        ctrl_o.upd_v   = 1'b1;
        ctrl_o.upd_z   = 1'b1;
      end
      ClsBranch: begin
        // alu_op carries the branch condition
        ctrl_o.alu_op  = op_i[2:0];
        ctrl_o.branch  = 1'b1;
        ctrl_o.use_imm = 1'b1;
      end
      ClsMisc: begin
        case (op_i)
          OpLd: begin
            ctrl_o.load    = 1'b1;
            ctrl_o.re_s    = 1'b1;
            ctrl_o.use_imm = 1'b1;
            ctrl_o.use_dst = 1'b1;
          end
          OpSt: begin
            ctrl_o.store   = 1'b1;
            ctrl_o.re_s    = 1'b1;
            ctrl_o.re_t    = 1'b1;
            ctrl_o.use_imm = 1'b1;
          end
          OpSprRd: begin
            ctrl_o.sprite_re = 1'b1;
            ctrl_o.use_dst   = 1'b1;
          end
          OpSprWr: begin
            ctrl_o.sprite_we = 1'b1;
            ctrl_o.re_s      = 1'b1;
          end
          OpSprAct: ctrl_o.sprite_act = 1'b1;
          OpHlt:    ctrl_o.is_hlt     = 1'b1;
          default:  ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_decode_pipe.sv
// Decode stage with ID/EX register, load-use stall, flush and sticky HLT.
// Optional WB->ID forwarding ports are enabled by defining ID_FWD_EN.
module instr_decode_pipe
  import instr_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned RADDR_W    = DefRaddrW,
  parameter int unsigned IMM_W      = DefImmW,
  parameter int unsigned SPR_ADDR_W = DefSprAddrW,
  parameter int unsigned PC_W       = DefPcW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               flush,
  output logic               reS,
  output logic               reT,
  output logic [RADDR_W-1:0] regS_addr,
  output logic [RADDR_W-1:0] regT_addr,
  input  logic [DATA_W-1:0]  regS_data,
  input  logic [DATA_W-1:0]  regT_data,
  output logic               out_valid,
  input  logic               out_ready,
  output id_ex_t             dec_o,
  output logic               hlt
`ifdef ID_FWD_EN
  ,
  input  logic               fwd_we,
  input  logic [RADDR_W-1:0] fwd_addr,
  input  logic [DATA_W-1:0]  fwd_data
`endif
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e             state_q;
  logic               valid_q;
  id_ex_t             dec_q;
  id_ex_t             dec_new;
  ctrl_t              ctrl;
  logic [RADDR_W-1:0] rd, rs, rt;
  logic [DATA_W-1:0]  s_data, t_data;
  logic               hazard, load_en, accept;

  assign rd = instr[RdLsb +: RADDR_W];
  assign rs = instr[RsLsb +: RADDR_W];
  assign rt = instr[RtLsb +: RADDR_W];

  id_field_dec u_field_dec (
    .op_i   (instr[OpLsb +: 5]),
    .ctrl_o (ctrl)
  );

  assign reS       = in_valid & ctrl.re_s;
  assign reT       = in_valid & ctrl.re_t;
  assign regS_addr = rs;
  assign regT_addr = rt;

  always_comb begin
    s_data = (rs == '0) ? '0 : regS_data;
    t_data = (rt == '0) ? '0 : regT_data;
`ifdef ID_FWD_EN
    if (fwd_we && (fwd_addr != '0) && (fwd_addr == rs)) s_data = fwd_data;
    if (fwd_we && (fwd_addr != '0) && (fwd_addr == rt)) t_data = fwd_data;
`endif
  end

  // A held load whose destination feeds the incoming instruction must drain first
  assign hazard = valid_q && dec_q.load && dec_q.use_dst && (dec_q.dst_reg != '0) &&
                  ((ctrl.re_s && (dec_q.dst_reg == rs)) || (ctrl.re_t && (dec_q.dst_reg == rt)));
  assign load_en  = !valid_q || out_ready;
  assign in_ready = (state_q == StRun) && load_en && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_new               = '0;
    dec_new.alu_op        = ctrl.alu_op;
    dec_new.imm           = instr[IMM_W-1:0];
    dec_new.reg_s_data    = s_data;
    dec_new.reg_t_data    = t_data;
    dec_new.dst_reg       = rd;
    dec_new.use_imm       = ctrl.use_imm;
    dec_new.use_dst       = ctrl.use_dst;
    dec_new.branch        = ctrl.branch;
    dec_new.load          = ctrl.load;
    dec_new.store         = ctrl.store;
    dec_new.sprite_re     = ctrl.sprite_re;
    dec_new.sprite_we     = ctrl.sprite_we;
    dec_new.sprite_action = ctrl.sprite_act ? instr[ActLsb +: 4] : 4'h0;
    dec_new.sprite_addr   = (ctrl.sprite_re || ctrl.sprite_we || ctrl.sprite_act) ?
                            instr[SPR_ADDR_W-1:0] : '0;
    dec_new.upd_n         = ctrl.upd_n;
    dec_new.upd_c         = ctrl.upd_c;
    dec_new.upd_v         = ctrl.upd_v;
    dec_new.upd_z         = ctrl.upd_z;
    dec_new.pc            = pc_in;
  end

  // Flush drops both the held and the offered instruction, including an offered HLT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (load_en) begin
        valid_q <= accept;
        if (accept) dec_q <= dec_new;
        if (accept && ctrl.is_hlt) state_q <= StHalted;
      end
    end
  end

  assign out_valid = valid_q;
  assign dec_o     = dec_q;
  assign hlt       = (state_q == StHalted);

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed self-checking bench for instr_decode_pipe (forwarding test only with ID_FWD_EN).
module tb_instr_decode_pipe;
  import instr_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [21:0] pc_in;
  logic        flush;
  logic        reS, reT;
  logic [4:0]  regS_addr, regT_addr;
  logic [31:0] regS_data, regT_data;
  logic        out_valid;
  logic        out_ready;
  id_ex_t      dec_o;
  logic        hlt;
`ifdef ID_FWD_EN
  logic        fwd_we;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  int checks;
  int failures;
  logic [31:0] rf [32];

  instr_decode_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc_in     (pc_in),
    .flush     (flush),
    .reS       (reS),
    .reT       (reT),
    .regS_addr (regS_addr),
    .regT_addr (regT_addr),
    .regS_data (regS_data),
    .regT_data (regT_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dec_o     (dec_o),
    .hlt       (hlt)
`ifdef ID_FWD_EN
    ,
    .fwd_we    (fwd_we),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    regS_data = rf[regS_addr];
    regT_data = rf[regT_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    mk = {op, rd, rs, rt, 12'h000};
  endfunction

  function automatic logic [31:0] mki(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [16:0] imm);
    mki = {op, rd, rs, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (hlt !== 1'b0) begin failures++; $display("FAIL rst_hlt got=%0b exp=0", hlt); end
    checks++; if (dec_o !== '0) begin failures++; $display("FAIL rst_dec_o got=%0h exp=0", dec_o); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_alu();
    in_valid = 1'b1; instr = mk(5'h00, 5'd3, 5'd1, 5'd2); pc_in = 22'h10;
    #1;
    checks++; if ({reS, reT} !== 2'b11) begin failures++; $display("FAIL add_re got=%0b exp=11", {reS, reT}); end
    checks++; if (regS_addr !== 5'd1) begin failures++; $display("FAIL add_saddr got=%0d exp=1", regS_addr); end
    checks++; if (regT_addr !== 5'd2) begin failures++; $display("FAIL add_taddr got=%0d exp=2", regT_addr); end
    tick();
    instr = mki(5'h0A, 5'd2, 5'd0, 17'h1ABCD); pc_in = 22'h11;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", out_valid); end
    checks++; if (dec_o.alu_op !== 3'd0) begin failures++; $display("FAIL add_aluop got=%0d exp=0", dec_o.alu_op); end
    checks++; if (dec_o.reg_s_data !== 32'd1) begin failures++; $display("FAIL add_sdata got=%0h exp=1", dec_o.reg_s_data); end
    checks++; if (dec_o.reg_t_data !== 32'd3) begin failures++; $display("FAIL add_tdata got=%0h exp=3", dec_o.reg_t_data); end
    checks++; if (dec_o.dst_reg !== 5'd3) begin failures++; $display("FAIL add_dst got=%0d exp=3", dec_o.dst_reg); end
    checks++; if ({dec_o.upd_n, dec_o.upd_z, dec_o.upd_c, dec_o.upd_v} !== 4'hF) begin
      failures++; $display("FAIL add_upd got=%0h exp=f", {dec_o.upd_n, dec_o.upd_z, dec_o.upd_c, dec_o.upd_v});
    end
    checks++; if (dec_o.pc !== 22'h10) begin failures++; $display("FAIL add_pc got=%0h exp=10", dec_o.pc); end
    tick();
    in_valid = 1'b0;
    checks++; if (dec_o.alu_op !== 3'd2) begin failures++; $display("FAIL imm_aluop got=%0d exp=2", dec_o.alu_op); end
    checks++; if (dec_o.use_imm !== 1'b1) begin failures++; $display("FAIL imm_use got=%0b exp=1", dec_o.use_imm); end
    checks++; if (dec_o.imm !== 17'h1ABCD) begin failures++; $display("FAIL imm_val got=%0h exp=1abcd", dec_o.imm); end
    checks++; if (dec_o.reg_s_data !== 32'd0) begin failures++; $display("FAIL imm_r0 got=%0h exp=0", dec_o.reg_s_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; instr = mki(5'h18, 5'd4, 5'd1, 17'h0);
    tick();
    instr = mk(5'h00, 5'd5, 5'd4, 5'd1);
    #1;
    checks++; if (dec_o.load !== 1'b1) begin failures++; $display("FAIL ld_held got=%0b exp=1", dec_o.load); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ld_stall got=%0b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ld_bubble got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ld_resume got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ld_add_valid got=%0b exp=1", out_valid); end
    checks++; if (dec_o.dst_reg !== 5'd5) begin failures++; $display("FAIL ld_add_dst got=%0d exp=5", dec_o.dst_reg); end
    checks++; if (dec_o.reg_s_data !== 32'h44) begin failures++; $display("FAIL ld_add_sdata got=%0h exp=44", dec_o.reg_s_data); end
    tick();
    // Load into r0 never stalls
    in_valid = 1'b1; instr = mki(5'h18, 5'd0, 5'd1, 17'h0);
    tick();
    instr = mk(5'h00, 5'd6, 5'd0, 5'd1);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ld_r0_nostall got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (dec_o.dst_reg !== 5'd6 || out_valid !== 1'b1) begin
      failures++; $display("FAIL ld_r0_next got=%0d/%0b exp=6/1", dec_o.dst_reg, out_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; instr = mk(5'h00, 5'd6, 5'd1, 5'd2);
    tick();
    out_ready = 1'b0; instr = mk(5'h01, 5'd7, 5'd2, 5'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || dec_o.dst_reg !== 5'd6) begin
        failures++; $display("FAIL bp_hold[%0d] got=%0b/%0d exp=1/6", i, out_valid, dec_o.dst_reg);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (dec_o.dst_reg !== 5'd7 || dec_o.alu_op !== 3'd1) begin
      failures++; $display("FAIL bp_next got=%0d/%0d exp=7/1", dec_o.dst_reg, dec_o.alu_op);
    end
    tick();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; instr = mki(5'h10, 5'd0, 5'd0, 17'h40); pc_in = 22'h100;
    tick();
    checks++; if (dec_o.branch !== 1'b1 || dec_o.use_dst !== 1'b0) begin
      failures++; $display("FAIL br_dec got=%0b/%0b exp=1/0", dec_o.branch, dec_o.use_dst);
    end
    out_ready = 1'b0; flush = 1'b1; instr = mk(5'h00, 5'd8, 5'd1, 5'd2);
    tick();
    flush = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    instr = mk(5'h00, 5'd9, 5'd1, 5'd2);
    tick();
    checks++; if (out_valid !== 1'b1 || dec_o.dst_reg !== 5'd9) begin
      failures++; $display("FAIL flush_next got=%0b/%0d exp=1/9", out_valid, dec_o.dst_reg);
    end
    // HLT offered together with flush is dropped
    flush = 1'b1; instr = 32'hF800_0000;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (hlt !== 1'b0) begin failures++; $display("FAIL flush_hlt got=%0b exp=0", hlt); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_hlt_state got=%0b/%0b exp=0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_halt();
    in_valid = 1'b1; instr = 32'hF800_0000;
    tick();
    out_ready = 1'b0; instr = mk(5'h00, 5'd3, 5'd1, 5'd2);
    #1;
    checks++; if (hlt !== 1'b1) begin failures++; $display("FAIL hlt_set got=%0b exp=1", hlt); end
    checks++; if (out_valid !== 1'b1 || dec_o.use_dst !== 1'b0 || dec_o.branch !== 1'b0) begin
      failures++; $display("FAIL hlt_nop got=%0b/%0b/%0b exp=1/0/0", out_valid, dec_o.use_dst, dec_o.branch);
    end
    tick();
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hlt_in_ready got=%0b exp=0", in_ready); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (hlt !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL hlt_rst got=%0b/%0b exp=0/0", hlt, out_valid);
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hlt_rst_ready got=%0b exp=1", in_ready); end
  endtask

`ifdef ID_FWD_EN
  task automatic test_fwd();
    fwd_we = 1'b1; fwd_addr = 5'd1; fwd_data = 32'hDEAD;
    in_valid = 1'b1; instr = mk(5'h00, 5'd3, 5'd1, 5'd2);
    tick();
    instr = mk(5'h00, 5'd3, 5'd0, 5'd2);
    checks++; if (dec_o.reg_s_data !== 32'hDEAD) begin failures++; $display("FAIL fwd_hit got=%0h exp=dead", dec_o.reg_s_data); end
    tick();
    in_valid = 1'b0; fwd_we = 1'b0;
    checks++; if (dec_o.reg_s_data !== 32'h0) begin failures++; $display("FAIL fwd_r0 got=%0h exp=0", dec_o.reg_s_data); end
    tick();
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'h99; rf[1] = 32'd1; rf[2] = 32'd3; rf[4] = 32'h44;
    in_valid = 1'b0; instr = '0; pc_in = '0; flush = 1'b0; out_ready = 1'b1;
`ifdef ID_FWD_EN
    fwd_we = 1'b0; fwd_addr = '0; fwd_data = '0;
`endif
    test_reset();
    test_alu();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_halt();
`ifdef ID_FWD_EN
    test_fwd();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
